pkfb_push_arbiter: RTL and testbench
====================================

// Module: pkfb_push_arbiter
// PURPOSE
//  Shares the ASSP packet-FIFO push port (FB_PKfbData/Push/SOF/EOF) among up to 4 fabric producers.
//  Grants whole packets (SOF..EOF) round-robin, routes each producer to a fixed packet-FIFO channel.
//  On FB_PKfbOverflow it drains the rest of the packet and latches a sticky per-producer error.
//  Sits in the fabric between the producers and the ASSP primitive, clocked by the ASSP packet clock.
// PARAMETERS
//  N_REQ     4        number of producers, 1..4
//  CHAN_MAP  8'hE4    2 bits per producer: packet-FIFO channel for producer i = CHAN_MAP[2i+1:2i]
//  CNT_W     16       width of the saturating word counter
// PORTS
//  Sys_PKfb_Clk     in   1        block clock; also drives the ASSP Sys_PKfb_Clk input
//  Sys_PKfb_Rst     in   1        reset, asynchronous, active-high
//  req_valid        in   N_REQ    producer i presents a word
//  req_data         in   32*N_REQ word of producer i at [32i+31:32i]
//  req_eof          in   N_REQ    word is the last of its packet
//  req_ready        out  N_REQ    producer i's word is accepted this cycle
//  FB_PKfbData      out  32       to ASSP
//  FB_PKfbPush      out  4        one-hot push to ASSP channel; all zero when idle
//  FB_PKfbSOF       out  1        to ASSP
//  FB_PKfbEOF       out  1        to ASSP
//  FB_PKfbOverflow  in   1        from ASSP; valid in the cycle FB_PKfbPush != 0
//  ovf_clr          in   N_REQ    pulse: clears ovf_sticky[i]
//  ovf_sticky       out  N_REQ    producer i lost data to overflow
//  busy             out  1        state != IDLE
//  word_cnt         out  CNT_W    words pushed in the current or last packet, saturating
// BEHAVIOUR
//  Reset: state IDLE, RR pointer 0, grant 0; all outputs 0 (req_ready, Push, SOF, EOF, Data,
//   ovf_sticky, busy, word_cnt). A reset mid-packet drops the packet; no EOF is emitted.
//  Transfer: req_valid[i] & req_ready[i] on a rising edge. req_ready[i] = grant[i] & state in XFER or DRAIN.
//  FSM:
//   IDLE:  if any req_valid, pick the first requester at or after the RR pointer, set grant, go XFER.
//          1 cycle of arbitration; no word is accepted in IDLE.
//   XFER:  each transfer drives the output register on the same edge, so outputs appear 1 cycle later:
//          Push = onehot(CHAN_MAP[i]), Data = word, SOF = first word of the grant, EOF = req_eof.
//          A transfer with req_eof goes to IDLE and sets the RR pointer to i+1 mod N_REQ.
//          A single-word packet gets SOF = EOF = 1.
//   DRAIN: accept and discard words from the granted producer; Push = 0.
//          A transfer with req_eof goes to IDLE and advances the RR pointer.
//  Overflow: sampled on an edge where registered Push != 0 and FB_PKfbOverflow = 1.
//   - Set ovf_sticky[grant].
//   - The word accepted on that edge is not pushed (the output register loads Push = 0).
//   - If that accepted word had req_eof, go to IDLE; otherwise go to DRAIN.
//   - Overflow on the EOF word itself (the last Push of the packet) only sets ovf_sticky; the state is already IDLE.
//  Push, SOF and EOF are held high for 1 cycle per transfer only; otherwise they are 0. Data holds its last value.
//  ovf_sticky: a set and ovf_clr in the same cycle leaves it set (set wins).
//  word_cnt: cleared on each SOF push, +1 per push, saturates at 2^CNT_W-1 (no wrap).
//  Non-granted producers see req_ready = 0; a lock is never broken except by reset.
//  Throughput: 1 word per cycle in XFER; 1 idle cycle between packets.
// STRUCTURE
//  Shared package/include pkfb_defs: FSM encodings (IDLE/XFER/DRAIN), PKFB_NUM_CHAN = 4,
//   PKFB_CHAN_W = 2, PKFB_DATA_W = 32.
//  Sub-module rr_arbiter (N, req, ptr -> one-hot gnt, combinational).
//  The top holds the FSM, the output register, the counters and the sticky flags.
// TESTING
//  1. Single packet: producer 0 sends 3 words A,B,C with eof on C.
//     -> Push = 4'b0001 for 3 cycles; SOF on A, EOF on C; word_cnt = 3; busy then drops.
//  2. Contention: producers 0 and 2 hold valid, CHAN_MAP = 8'hE4, each sends a 2-word packet.
//     -> packets are not interleaved; order is 0 then 2; Push = 0001,0001 then 0100,0100; RR pointer = 3.
//  3. Single-word packet with eof on the first word -> one push with SOF = EOF = 1; state back to IDLE.
//  4. Overflow on the 2nd push of a 5-word packet.
//     -> the remaining words are accepted and not pushed; ovf_sticky[0] = 1; IDLE after eof.
//     -> ovf_clr[0] clears it; a simultaneous set and clr leaves it 1.
//  5. Sys_PKfb_Rst asserted mid-XFER (async, between edges).
//     -> all outputs 0 immediately; the next packet starts with SOF and word_cnt = 1.
//  6. CNT_W = 4 with a 20-word packet -> word_cnt saturates at 15; packet data is intact.

Source files
------------

// File: rtl/pkfb_defs.sv
// Shared definitions for the packet-FIFO push arbiter.
//   pkfb_state_e  : arbiter FSM encoding
//   PKFB_*        : ASSP packet-FIFO port geometry
//   chan_onehot() : turns a producer's 2-bit channel field into a one-hot push vector
package pkfb_defs;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_DRAIN = 2'd2
   } pkfb_state_e;

   localparam int PKFB_NUM_CHAN = 4;
   localparam int PKFB_CHAN_W   = 2;
   localparam int PKFB_DATA_W   = 32;

   function automatic logic [PKFB_NUM_CHAN-1:0] chan_onehot(
      input logic [PKFB_CHAN_W*PKFB_NUM_CHAN-1:0] map,
      input int                                   idx
   );
      logic [PKFB_CHAN_W-1:0] ch;
      ch = PKFB_CHAN_W'(map >> (PKFB_CHAN_W * idx));
      return PKFB_NUM_CHAN'(1) << ch;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: grants the first requester at or after i_ptr.
//   i_req [N]      request vector
//   i_ptr [PTR_W]  index with highest priority
//   o_gnt [N]      one-hot grant, zero when nothing requests
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_req,
   input  logic [PTR_W-1:0] i_ptr,
   output logic [N-1:0]     o_gnt
);

   always_comb begin
      logic w_found;
      o_gnt   = '0;
      w_found = 1'b0;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < N; j++) begin
            if (!w_found && i_req[j] && (j == (int'(i_ptr) + k) % N)) begin
               o_gnt[j] = 1'b1;
               w_found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/pkfb_push_arbiter.sv
// Shares the ASSP packet-FIFO push port among up to four fabric producers.
// Whole packets (first word .. eof word) are granted round-robin; each producer
// is routed to a fixed packet-FIFO channel taken from CHAN_MAP.
//   Sys_PKfb_Clk / Sys_PKfb_Rst      clock, async active-high reset
//   req_valid/req_data/req_eof       producer words;  req_ready accepts them
//   FB_PKfb*                         registered push port toward the ASSP
//   FB_PKfbOverflow                  ASSP overflow for the push currently on the port
//   ovf_clr / ovf_sticky             per-producer overflow flags (set wins over clear)
//   busy                             FSM not idle
//   word_cnt                         pushes in the current/last packet, saturating
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no grant active; one cycle spent picking the next producer
// ST_XFER  | granted producer's words are pushed, one per accepted word
// ST_DRAIN | overflow hit: remaining words are accepted and discarded
module pkfb_push_arbiter
   import pkfb_defs::*;
#(
   parameter int                                      N_REQ    = 4,
   parameter logic [PKFB_CHAN_W*PKFB_NUM_CHAN-1:0]    CHAN_MAP = 8'hE4,
   parameter int                                      CNT_W    = 16
) (
   input  logic                           Sys_PKfb_Clk,
   input  logic                           Sys_PKfb_Rst,
   input  logic [N_REQ-1:0]               req_valid,
   input  logic [PKFB_DATA_W*N_REQ-1:0]   req_data,
   input  logic [N_REQ-1:0]               req_eof,
   output logic [N_REQ-1:0]               req_ready,
   output logic [PKFB_DATA_W-1:0]         FB_PKfbData,
   output logic [PKFB_NUM_CHAN-1:0]       FB_PKfbPush,
   output logic                           FB_PKfbSOF,
   output logic                           FB_PKfbEOF,
   input  logic                           FB_PKfbOverflow,
   input  logic [N_REQ-1:0]               ovf_clr,
   output logic [N_REQ-1:0]               ovf_sticky,
   output logic                           busy,
   output logic [CNT_W-1:0]               word_cnt
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   pkfb_state_e                r_state;
   pkfb_state_e                w_state_nxt;
   logic [PTR_W-1:0]           r_ptr;
   logic [PTR_W-1:0]           r_gidx;
   logic                       r_first;
   logic [PKFB_DATA_W-1:0]     r_data;
   logic [PKFB_NUM_CHAN-1:0]   r_push;
   logic                       r_sof;
   logic                       r_eof;
   logic [N_REQ-1:0]           r_sticky;
   logic [CNT_W-1:0]           r_cnt;

   logic [N_REQ-1:0]           w_arb_gnt;
   logic [PTR_W-1:0]           w_arb_idx;
   logic [N_REQ-1:0]           w_grant;
   logic                       w_sel_valid;
   logic                       w_sel_eof;
   logic [PKFB_DATA_W-1:0]     w_sel_data;
   logic [PKFB_NUM_CHAN-1:0]   w_push_oh;
   logic                       w_active;
   logic                       w_xfer;
   logic                       w_ovf;
   logic                       w_push_word;
   logic                       w_arb_take;
   logic [PTR_W-1:0]           w_ptr_inc;

   rr_arbiter #(
      .N     (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .i_req (req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt)
   );

   always_comb begin
      w_arb_idx = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (w_arb_gnt[j]) w_arb_idx = PTR_W'(j);
      end
   end

   // Granted producer's request, data and channel routing.
   always_comb begin
      w_grant     = '0;
      w_sel_valid = 1'b0;
      w_sel_eof   = 1'b0;
      w_sel_data  = '0;
      w_push_oh   = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (r_gidx == PTR_W'(j)) begin
            w_grant[j]  = 1'b1;
            w_sel_valid = req_valid[j];
            w_sel_eof   = req_eof[j];
            w_sel_data  = req_data[PKFB_DATA_W*j +: PKFB_DATA_W];
            w_push_oh   = chan_onehot(CHAN_MAP, j);
         end
      end
   end

   assign w_active    = (r_state == ST_XFER) || (r_state == ST_DRAIN);
   assign w_xfer      = w_active && w_sel_valid;
   // Overflow refers to the push sitting on the port now, i.e. the previous word.
   assign w_ovf       = (|r_push) && FB_PKfbOverflow;
   assign w_push_word = w_xfer && (r_state == ST_XFER) && !w_ovf;
   assign w_arb_take  = (r_state == ST_IDLE) && (|req_valid);
   assign w_ptr_inc   = (r_gidx == PTR_W'(N_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);

   always_ff @(posedge Sys_PKfb_Clk or posedge Sys_PKfb_Rst) begin
      if (Sys_PKfb_Rst) r_state <= ST_IDLE;
      else              r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (|req_valid) w_state_nxt = ST_XFER;
         ST_XFER: begin
            if (w_xfer && w_sel_eof) w_state_nxt = ST_IDLE;
            else if (w_ovf)          w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: if (w_xfer && w_sel_eof) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = w_active ? w_grant : '0;
      busy      = (r_state != ST_IDLE);
   end

   // Grant index is kept through IDLE so a late overflow on the eof push is
   // still charged to the producer that owned it.
   always_ff @(posedge Sys_PKfb_Clk or posedge Sys_PKfb_Rst) begin
      if (Sys_PKfb_Rst) begin
         r_ptr   <= '0;
         r_gidx  <= '0;
         r_first <= 1'b0;
      end else begin
         if (w_arb_take) begin
            r_gidx  <= w_arb_idx;
            r_first <= 1'b1;
         end else if (w_xfer) begin
            r_first <= 1'b0;
         end
         if (w_xfer && w_sel_eof) r_ptr <= w_ptr_inc;
      end
   end

   always_ff @(posedge Sys_PKfb_Clk or posedge Sys_PKfb_Rst) begin
      if (Sys_PKfb_Rst) begin
         r_data <= '0;
         r_push <= '0;
         r_sof  <= 1'b0;
         r_eof  <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_push <= '0;
         r_sof  <= 1'b0;
         r_eof  <= 1'b0;
         if (w_push_word) begin
            r_push <= w_push_oh;
            r_sof  <= r_first;
            r_eof  <= w_sel_eof;
            r_data <= w_sel_data;
            if (r_first)     r_cnt <= CNT_W'(1);
            else if (~&r_cnt) r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge Sys_PKfb_Clk or posedge Sys_PKfb_Rst) begin
      if (Sys_PKfb_Rst) r_sticky <= '0;
      else              r_sticky <= (r_sticky & ~ovf_clr) | (w_ovf ? w_grant : '0);
   end

   assign FB_PKfbData = r_data;
   assign FB_PKfbPush = r_push;
   assign FB_PKfbSOF  = r_sof;
   assign FB_PKfbEOF  = r_eof;
   assign ovf_sticky  = r_sticky;
   assign word_cnt    = r_cnt;

endmodule

// File: tb/tb_pkfb_push_arbiter.sv
module tb_pkfb_push_arbiter;

   localparam int         N    = 4;
   localparam logic [7:0] MAP  = 8'hE4;
   localparam int         CW   = 4;
   localparam int         CMAX = 15;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   req_valid = '0;
   logic [127:0] req_data  = '0;
   logic [3:0]   req_eof   = '0;
   logic [3:0]   req_ready;
   logic [31:0]  pk_data;
   logic [3:0]   push;
   logic         sof, eof;
   logic         ovf = 1'b0;
   logic [3:0]   ovf_clr = '0;
   logic [3:0]   ovf_sticky;
   logic         busy;
   logic [CW-1:0] word_cnt;

   pkfb_push_arbiter #(.N_REQ(N), .CHAN_MAP(MAP), .CNT_W(CW)) dut (
      .Sys_PKfb_Clk    (clk),
      .Sys_PKfb_Rst    (rst),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_eof         (req_eof),
      .req_ready       (req_ready),
      .FB_PKfbData     (pk_data),
      .FB_PKfbPush     (push),
      .FB_PKfbSOF      (sof),
      .FB_PKfbEOF      (eof),
      .FB_PKfbOverflow (ovf),
      .ovf_clr         (ovf_clr),
      .ovf_sticky      (ovf_sticky),
      .busy            (busy),
      .word_cnt        (word_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (packet level) ----------------
   typedef struct packed {
      logic [31:0] d;
      logic        e;
   } word_t;

   word_t       q[N][$];
   bit          mid[N];
   logic [3:0]  m_ready, m_push, m_sticky;
   logic [31:0] m_data;
   logic        m_sof, m_eof;
   int          m_cnt, m_ptr, m_owner, m_last;
   bit          m_drain, m_first;
   logic [3:0]  obs_push[$];

   bit          k_bubble, k_rand_ovf, k_rand_clr, k_clr_with_ovf;
   int          k_force_cnt;
   logic [3:0]  k_clr_once;

   function automatic int chan(input int p);
      return (int'(MAP) >> (2 * p)) & 3;
   endfunction

   function automatic int rr_pick(input logic [3:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (((int'(v) >> ((ptr + k) % N)) & 1) != 0) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ready = '0; m_push = '0; m_sticky = '0; m_data = '0;
      m_sof = 1'b0; m_eof = 1'b0; m_cnt = 0; m_ptr = 0; m_owner = -1; m_last = 0;
      m_drain = 1'b0; m_first = 1'b0;
      for (int i = 0; i < N; i++) begin
         q[i].delete();
         mid[i] = 1'b0;
      end
      obs_push.delete();
   endtask

   task automatic add_pkt(input int p, input int len);
      word_t w;
      for (int i = 0; i < len; i++) begin
         w.d = $urandom;
         w.e = (i == len - 1);
         q[p].push_back(w);
      end
   endtask

   // One clock: compare outputs with the model, drive inputs, advance the model.
   task automatic step();
      logic [3:0] v, clr, set, n_push;
      logic       ovf_drv, ovf_eff, n_sof, n_eof;
      word_t      w;
      int         p;
      @(negedge clk);
      check("ready",    {28'b0, req_ready},  {28'b0, m_ready});
      check("busy",     {31'b0, busy},       {31'b0, (m_ready != 0)});
      check("push",     {28'b0, push},       {28'b0, m_push});
      check("sof",      {31'b0, sof},        {31'b0, m_sof});
      check("eof",      {31'b0, eof},        {31'b0, m_eof});
      check("data",     pk_data,             m_data);
      check("word_cnt", {28'b0, word_cnt},   32'(m_cnt));
      check("sticky",   {28'b0, ovf_sticky}, {28'b0, m_sticky});
      if (push != 0) obs_push.push_back(push);

      v = '0; clr = '0; set = '0;
      for (int i = 0; i < N; i++) begin
         if (q[i].size() > 0) begin
            req_data[32*i +: 32] = q[i][0].d;
            req_eof[i]           = q[i][0].e;
            v[i] = !(k_bubble && mid[i] && ($urandom_range(0, 3) == 0));
         end else begin
            req_data[32*i +: 32] = $urandom;
            req_eof[i]           = 1'($urandom_range(0, 1));
         end
      end
      req_valid = v;

      ovf_drv = 1'b0;
      if (k_force_cnt >= 0) begin
         if (push != 0 && int'(word_cnt) == k_force_cnt) begin
            ovf_drv     = 1'b1;
            k_force_cnt = -1;
         end
      end else if (k_rand_ovf) begin
         ovf_drv = ($urandom_range(0, 5) == 0);
      end
      if (k_rand_clr && $urandom_range(0, 15) == 0) clr = clr | (4'(1) << $urandom_range(0, 3));
      clr        = clr | k_clr_once;
      k_clr_once = '0;
      ovf_eff    = ovf_drv && (m_push != 0);
      if (ovf_eff) begin
         set = 4'(1) << m_last;
         if (k_clr_with_ovf) clr = clr | set;
      end
      ovf     = ovf_drv;
      ovf_clr = clr;

      n_push = '0; n_sof = 1'b0; n_eof = 1'b0;
      if (m_ready != 0) begin
         p = m_owner;
         if (((int'(v) >> p) & 1) != 0) begin
            w      = q[p].pop_front();
            mid[p] = 1'b1;
            if (!ovf_eff && !m_drain) begin
               n_push = 4'(1) << chan(p);
               n_sof  = m_first;
               n_eof  = w.e;
               m_data = w.d;
               m_cnt  = m_first ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
               m_last = p;
            end else if (!w.e) begin
               m_drain = 1'b1;
            end
            m_first = 1'b0;
            if (w.e) begin
               m_ready = '0;
               m_ptr   = (p + 1) % N;
               mid[p]  = 1'b0;
               m_drain = 1'b0;
               m_owner = -1;
            end
         end else if (ovf_eff) begin
            m_drain = 1'b1;
         end
      end else if (v != 0) begin
         p       = rr_pick(v, m_ptr);
         m_owner = p;
         m_ready = 4'(1) << p;
         m_first = 1'b1;
         m_drain = 1'b0;
      end
      m_push   = n_push;
      m_sof    = n_sof;
      m_eof    = n_eof;
      m_sticky = (m_sticky & ~clr) | set;
   endtask

   task automatic run_idle(input int budget, input string name);
      int n;
      bit pend;
      n    = 0;
      pend = 1'b1;
      while (pend && n < budget) begin
         step();
         n++;
         pend = (m_ready != 0);
         for (int i = 0; i < N; i++) if (q[i].size() > 0) pend = 1'b1;
      end
      check({name, "_timeout"}, {31'b0, pend}, 32'd0);
      step();
      step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = '0; req_eof = '0; req_data = '0; ovf = 1'b0; ovf_clr = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------- directed table: single packet then single-word packet ----------------
   typedef struct {
      logic [3:0]  v;
      logic [31:0] d;
      logic        e;
      logic [3:0]  x_push;
      logic        x_sof, x_eof;
      logic [31:0] x_data;
      logic        x_busy;
      int          x_cnt;
      logic [3:0]  x_ready;
   } vec_t;

   vec_t tv[8];

   initial begin
      int n;
      k_bubble = 0; k_rand_ovf = 0; k_rand_clr = 0; k_clr_with_ovf = 0;
      k_force_cnt = -1; k_clr_once = '0;
      model_reset();

      //        v      data          e   push  sof eof  data          busy cnt ready
      tv[0] = '{4'h1, 32'hA000_000A, 0, 4'h0, 0,  0,  32'h0,         0,   0,  4'h0};
      tv[1] = '{4'h1, 32'hA000_000A, 0, 4'h0, 0,  0,  32'h0,         1,   0,  4'h1};
      tv[2] = '{4'h1, 32'hB000_000B, 0, 4'h1, 1,  0,  32'hA000_000A, 1,   1,  4'h1};
      tv[3] = '{4'h1, 32'hC000_000C, 1, 4'h1, 0,  0,  32'hB000_000B, 1,   2,  4'h1};
      tv[4] = '{4'h1, 32'hD000_000D, 1, 4'h1, 0,  1,  32'hC000_000C, 0,   3,  4'h0};
      tv[5] = '{4'h1, 32'hD000_000D, 1, 4'h0, 0,  0,  32'hC000_000C, 1,   3,  4'h1};
      tv[6] = '{4'h0, 32'h0,         0, 4'h1, 1,  1,  32'hD000_000D, 0,   1,  4'h0};
      tv[7] = '{4'h0, 32'h0,         0, 4'h0, 0,  0,  32'hD000_000D, 0,   1,  4'h0};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("tv_push",  {28'b0, push},      {28'b0, tv[i].x_push});
         check("tv_sof",   {31'b0, sof},       {31'b0, tv[i].x_sof});
         check("tv_eof",   {31'b0, eof},       {31'b0, tv[i].x_eof});
         check("tv_data",  pk_data,            tv[i].x_data);
         check("tv_busy",  {31'b0, busy},      {31'b0, tv[i].x_busy});
         check("tv_cnt",   {28'b0, word_cnt},  32'(tv[i].x_cnt));
         check("tv_ready", {28'b0, req_ready}, {28'b0, tv[i].x_ready});
         req_valid          = tv[i].v;
         req_data[31:0]     = tv[i].d;
         req_eof[0]         = tv[i].e;
      end

      // contention: producers 0 and 2, then 1 and 3 with pointer at 3
      do_reset();
      add_pkt(0, 2);
      add_pkt(2, 2);
      run_idle(40, "cont");
      check("cont_n",  32'(obs_push.size()), 32'd4);
      check("cont_p0", {28'b0, obs_push[0]}, 32'h1);
      check("cont_p1", {28'b0, obs_push[1]}, 32'h1);
      check("cont_p2", {28'b0, obs_push[2]}, 32'h4);
      check("cont_p3", {28'b0, obs_push[3]}, 32'h4);
      obs_push.delete();
      add_pkt(1, 1);
      add_pkt(3, 1);
      run_idle(40, "ptr3");
      check("ptr3_first",  {28'b0, obs_push[0]}, 32'h8);
      check("ptr3_second", {28'b0, obs_push[1]}, 32'h2);

      // overflow on 2nd push of a 5-word packet, then clear, then set+clear together
      obs_push.delete();
      k_force_cnt = 2;
      add_pkt(0, 5);
      run_idle(40, "ovf");
      check("ovf_pushes", 32'(obs_push.size()), 32'd2);
      check("ovf_sticky", {28'b0, ovf_sticky}, 32'h1);
      k_clr_once = 4'b0001;
      step();
      step();
      check("ovf_cleared", {28'b0, ovf_sticky}, 32'h0);
      k_force_cnt    = 1;
      k_clr_with_ovf = 1;
      add_pkt(0, 2);
      run_idle(40, "ovf_setclr");
      check("ovf_set_wins", {28'b0, ovf_sticky}, 32'h1);
      k_clr_with_ovf = 0;
      k_force_cnt    = -1;

      // asynchronous reset in the middle of a packet
      add_pkt(1, 6);
      n = 0;
      while (word_cnt != 2 && n < 20) begin
         step();
         n++;
      end
      check("rst_reach", 32'(n < 20), 32'd1);
      #2;
      rst = 1'b1; req_valid = '0; ovf = 1'b0; ovf_clr = '0;
      #1;
      check("rst_push",   {28'b0, push},       32'h0);
      check("rst_ready",  {28'b0, req_ready},  32'h0);
      check("rst_busy",   {31'b0, busy},       32'h0);
      check("rst_cnt",    {28'b0, word_cnt},   32'h0);
      check("rst_data",   pk_data,             32'h0);
      check("rst_sofeof", {30'b0, sof, eof},   32'h0);
      check("rst_sticky", {28'b0, ovf_sticky}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      add_pkt(1, 3);
      run_idle(40, "post_rst");
      check("post_rst_n", 32'(obs_push.size()), 32'd3);

      // 20-word packet against a 4-bit counter
      obs_push.delete();
      add_pkt(2, 20);
      run_idle(80, "sat");
      check("sat_cnt", {28'b0, word_cnt}, 32'd15);
      check("sat_n",   32'(obs_push.size()), 32'd20);

      // randomized traffic with bubbles, overflows and clears
      do_reset();
      k_bubble = 1; k_rand_ovf = 1; k_rand_clr = 1;
      for (int r = 0; r < 3; r++)
         for (int p = 0; p < N; p++) add_pkt(p, $urandom_range(1, 20));
      run_idle(4000, "rand");
      k_rand_ovf = 0;
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < N; p++) add_pkt(p, $urandom_range(1, 8));
      run_idle(2000, "rand2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
